// File: rtl/rom_stream_reader.sv
// Burst reader for the synchronous 16x4 ROM: issues sequential reads and re-times the data into a valid/ready stream.
// Optional running XOR of delivered beats on 'checksum' when ROM_STREAM_READER_CHECKSUM_EN is defined.
module rom_stream_reader #(
    parameter int AW = 4,
    parameter int DW = 4,
    parameter int LW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [LW-1:0] length,
    output logic          busy,
    output logic          done,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_dout,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready
`ifdef ROM_STREAM_READER_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } state_t;

    state_t state;
    state_t next_state;

    logic [AW-1:0] cur_addr;
    logic [LW-1:0] remaining;

    // track[0] mirrors rom_en (ROM samples next edge); track[1] means rom_dout is valid now
    logic [1:0]    track;
    logic [1:0]    inflight;
    logic [3:0]    occupancy;

    logic [DW-1:0] fifo_mem [4];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [2:0]    fifo_count;

    logic          push;
    logic          pop;
    logic          issue;
    logic          accept;

    always_comb begin
        inflight  = {1'b0, track[0]} + {1'b0, track[1]};
        occupancy = {1'b0, fifo_count} + {2'b00, inflight};
        push      = track[1];
        m_valid   = (fifo_count != 3'd0);
        m_data    = fifo_mem[rd_ptr];
        pop       = m_valid & m_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        issue      = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept     = 1'b1;
                    next_state = (length == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                // Never let buffered plus in-flight words exceed the 4-entry buffer
                if (occupancy < 4'd4) begin
                    issue = 1'b1;
                    if (remaining == LW'(1)) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Look ahead at the final pop so done follows the last beat by one cycle
                if (inflight == 2'd0 &&
                    (fifo_count == 3'd0 || (fifo_count == 3'd1 && pop))) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            track     <= 2'b00;
        end else begin
            rom_en <= issue;
            track  <= {track[0], issue};
            if (accept) begin
                cur_addr  <= start_addr;
                remaining <= length;
            end else if (issue) begin
                rom_addr  <= cur_addr;
                cur_addr  <= cur_addr + AW'(1);
                remaining <= remaining - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= rom_dout;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef ROM_STREAM_READER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum ^ m_data;
        end
    end
`endif

endmodule
